fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-stage producer for the IF/ID pipeline register: owns the PC, drives the IM address,
//  and emits per-fetch instr/pc/pc8/ADEL/BD payload consumed by the IF/ID register.
//  Applies redirect priority: exception entry, eret, stall, D-stage branch/jump, sequential.
//  Tracks branch-delay-slot status so the BD bit needed for EPC/Cause.BD is registered at fetch.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC loaded on reset
//  EXC_VEC   32'h0000_4180  exception handler entry
//  IM_LO     32'h0000_3000  lowest legal fetch address
//  IM_HI     32'h0000_6FFC  highest legal fetch address
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  stall        in   1   hazard stall: hold PC and BD state
//  exc_req      in   1   exception/interrupt taken in M: vector to EXC_VEC
//  eret_m       in   1   eret in M: resume at epc
//  epc          in   32  CP0 EPC value
//  redir_valid  in   1   D-stage branch taken or jump (j/jal/jr/jalr)
//  redir_target in   32  D-stage computed target
//  im_rdata     in   32  instruction word read at im_addr (combinational IM)
//  im_addr      out  32  IM read address (= pc_f)
//  instr_f      out  32  fetched instruction; 0 when adel_f
//  pc_f         out  32  PC of instr_f
//  pc8_f        out  32  pc_f + 8 (link value)
//  adel_f       out  1   fetch address error
//  bd_f         out  1   instr_f sits in a branch delay slot
// BEHAVIOUR
//  - Registers: pc_q[31:0], bd_q. Reset: pc_q=RESET_PC, bd_q=0 -> pc_f=32'h3000, pc8_f=32'h3008,
//    adel_f=0, bd_f=0, instr_f=im_rdata(0x3000).
//  - Next-state priority (per posedge): reset > exc_req > eret_m > stall > redir_valid > seq.
//      exc_req : pc_q<=EXC_VEC, bd_q<=0 (ignores stall/redir)
//      eret_m  : pc_q<=epc,     bd_q<=0 (ignores stall/redir); exc_req+eret_m same cycle -> EXC_VEC
//      stall   : pc_q, bd_q hold
//      redir   : pc_q<=redir_target, bd_q<=is_cti(instr_f)
//      seq     : pc_q<=pc_q+4 (mod 2^32 wrap), bd_q<=is_cti(instr_f)
//  - Delay-slot rule: redirect arrives while the branch is in D, i.e. one cycle after its fetch;
//    the instruction fetched in that cycle (pc+4) is the delay slot and gets bd_f=1.
//  - is_cti: opcode 000100/000101/000110/000111 (beq,bne,blez,bgtz), 000001 (REGIMM, all rt incl.
//    bgezall), 000010/000011 (j,jal), 000000 with funct 001000/001001 (jr,jalr). Else 0.
//  - adel_f = (pc_q[1:0]!=0) | (pc_q<IM_LO) | (pc_q>IM_HI); unsigned compares.
//  - When adel_f: instr_f=32'h0 (nop), so is_cti=0 and no false BD on the next fetch; pc_f still
//    carries the faulting address for EPC/BadVAddr; im_addr still driven (data ignored).
//  - bd_f=bd_q, combinationally valid all cycle; pc8_f=pc_q+8, 32-bit wrap.
//  - Output payload is combinational from pc_q/im_rdata: zero-cycle latency to the IF/ID register.
//  - Flushing IF/ID (exc/eret/likely-annul) belongs to the IF/ID register; this block only redirects.
//  - Reset mid-stall or mid-redirect: reset wins, no state retained.
// STRUCTURE
//  - Shared header (instruction-bus include): opcode/funct constants, RESET_PC/EXC_VEC/IM bounds.
//  - Sub-module fetch_cti_predecode: 32-bit instr -> is_cti (pure combinational classifier).
//  - Top: PC/BD registers, priority mux, ADEL check, output masking.
// TESTING
//  1. Reset 2 cycles, release -> pc_f 0x3000,0x3004,0x3008 on successive cycles; pc8_f 0x3008..; bd_f=0.
//  2. IM[0x3004]=beq (0x1000_0003); redir_valid=1, target 0x3014 in cycle fetching 0x3008 -> that
//     fetch bd_f=1; next pc_f=0x3014 with bd_f=0.
//  3. stall=1 for 3 cycles at pc 0x3010 -> pc_f stays 0x3010, bd_f unchanged; releases to 0x3014.
//  4. exc_req=1 with stall=1 and redir_valid=1 same cycle -> next pc_f=0x4180, bd_f=0.
//  5. eret_m=1, epc=0x3022 -> next pc_f=0x3022, adel_f=1, instr_f=0; following fetch bd_f=0.
//  6. redir_target=0x7000 -> adel_f=1, instr_f=0; exc_req next cycle -> pc_f=0x4180, adel_f=0.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
// Shared fetch-stage definitions: address map, opcode/funct encodings and
// the PC source selection used by the fetch unit.
package fetch_pc_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEFAULT    = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEFAULT    = 32'h0000_6FFC;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_HOLD,
    SEL_ERET,
    SEL_EXC
  } pc_sel_e;

  // Redirect priority: exception entry > eret > stall > D-stage redirect > sequential.
  function automatic pc_sel_e pc_select(input logic exc_req, input logic eret_m,
                                        input logic stall, input logic redir_valid);
    if (exc_req)          return SEL_EXC;
    else if (eret_m)      return SEL_ERET;
    else if (stall)       return SEL_HOLD;
    else if (redir_valid) return SEL_REDIR;
    else                  return SEL_SEQ;
  endfunction

  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/fetch_cti_predecode.sv
// Classifies a fetched word as a control-transfer instruction (branch/jump),
// which marks the next sequential fetch as a branch delay slot.
module fetch_cti_predecode
  import fetch_pc_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_cti
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  // Register/immediate fields carry no control-transfer information.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    is_cti = 1'b0;
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_cti = 1'b1;
      OP_REGIMM:                        is_cti = 1'b1;
      OP_J, OP_JAL:                     is_cti = 1'b1;
      OP_SPECIAL:                       is_cti = (fn == FN_JR) || (fn == FN_JALR);
      default:                          is_cti = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: selects the next PC, checks fetch address legality and
// produces the combinational instr/pc/pc8/adel/bd payload for the IF/ID register.
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT,
  parameter logic [31:0] IM_LO    = IM_LO_DEFAULT,
  parameter logic [31:0] IM_HI    = IM_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_m,
  input  logic [31:0] epc,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc8_f,
  output logic        adel_f,
  output logic        bd_f
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic        adel;
  logic        is_cti;
  pc_sel_e     sel;

  assign adel = addr_err(pc_q, IM_LO, IM_HI);
  // A faulting fetch becomes a nop so it can never flag the next fetch as a delay slot.
  assign instr_f = adel ? 32'h0 : im_rdata;

  fetch_cti_predecode u_predecode (
    .instr  (instr_f),
    .is_cti (is_cti)
  );

  always_comb begin
    pc_d = pc_q;
    bd_d = bd_q;
    sel  = pc_select(exc_req, eret_m, stall, redir_valid);
    case (sel)
      SEL_EXC: begin
        pc_d = EXC_VEC;
        bd_d = 1'b0;
      end
      SEL_ERET: begin
        pc_d = epc;
        bd_d = 1'b0;
      end
      SEL_HOLD: begin
        pc_d = pc_q;
        bd_d = bd_q;
      end
      SEL_REDIR: begin
        pc_d = redir_target;
        bd_d = is_cti;
      end
      default: begin
        pc_d = pc_q + 32'd4;
        bd_d = is_cti;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      bd_q <= bd_d;
    end
  end

  assign im_addr = pc_q;
  assign pc_f    = pc_q;
  assign pc8_f   = pc_q + 32'd8;
  assign adel_f  = adel;
  assign bd_f    = bd_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a small behavioural instruction memory.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic        eret_m;
  logic [31:0] epc;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] im_rdata;
  logic [31:0] im_addr;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc8_f;
  logic        adel_f;
  logic        bd_f;

  logic beq_en = 1'b0;
  logic jr_en  = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Illegal addresses return a jump so an unmasked fault would show up as a false BD.
  function automatic logic [31:0] im_word(input logic [31:0] a, input logic b_en, input logic j_en);
    if (a[1:0] != 2'b00 || a < 32'h3000 || a > 32'h6FFC) return 32'h0800_0000;
    if (b_en && a == 32'h3004) return 32'h1000_0003;
    if (j_en && a == 32'h300C) return 32'h03E0_0008;
    return 32'h2400_0000 | {16'h0, a[15:0]};
  endfunction

  assign im_rdata = im_word(im_addr, beq_en, jr_en);

  fetch_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .exc_req      (exc_req),
    .eret_m       (eret_m),
    .epc          (epc),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .im_rdata     (im_rdata),
    .im_addr      (im_addr),
    .instr_f      (instr_f),
    .pc_f         (pc_f),
    .pc8_f        (pc8_f),
    .adel_f       (adel_f),
    .bd_f         (bd_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_f, 32'h3000); end
    n_vec++; if (pc8_f !== 32'h3008) begin n_fail++; $display("FAIL reset_pc8 got %h exp %h", pc8_f, 32'h3008); end
    n_vec++; if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_imaddr got %h exp %h", im_addr, 32'h3000); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL reset_bd got %b exp 0", bd_f); end
    n_vec++; if (adel_f !== 1'b0) begin n_fail++; $display("FAIL reset_adel got %b exp 0", adel_f); end
    n_vec++; if (instr_f !== 32'h2400_3000) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instr_f, 32'h2400_3000); end
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    tick();
    n_vec++; if (pc_f !== 32'h3004) begin n_fail++; $display("FAIL seq_pc1 got %h exp %h", pc_f, 32'h3004); end
    n_vec++; if (pc8_f !== 32'h300C) begin n_fail++; $display("FAIL seq_pc8_1 got %h exp %h", pc8_f, 32'h300C); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL seq_bd1 got %b exp 0", bd_f); end
    tick();
    n_vec++; if (pc_f !== 32'h3008) begin n_fail++; $display("FAIL seq_pc2 got %h exp %h", pc_f, 32'h3008); end
    n_vec++; if (pc8_f !== 32'h3010) begin n_fail++; $display("FAIL seq_pc8_2 got %h exp %h", pc8_f, 32'h3010); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL seq_bd2 got %b exp 0", bd_f); end
  endtask

  task automatic test_redirect_bd();
    beq_en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_vec++; if (instr_f !== 32'h1000_0003) begin n_fail++; $display("FAIL br_instr got %h exp %h", instr_f, 32'h1000_0003); end
    tick();
    n_vec++; if (pc_f !== 32'h3008) begin n_fail++; $display("FAIL br_slot_pc got %h exp %h", pc_f, 32'h3008); end
    n_vec++; if (bd_f !== 1'b1) begin n_fail++; $display("FAIL br_slot_bd got %b exp 1", bd_f); end
    redir_valid = 1'b1;
    redir_target = 32'h3014;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc_f !== 32'h3014) begin n_fail++; $display("FAIL br_target_pc got %h exp %h", pc_f, 32'h3014); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL br_target_bd got %b exp 0", bd_f); end
    beq_en = 1'b0;
  endtask

  // Walks from reset to 0x3010, where the jr at 0x300C leaves bd_f=1.
  task automatic goto_3010();
    jr_en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_stall();
    goto_3010();
    n_vec++; if (pc_f !== 32'h3010) begin n_fail++; $display("FAIL stall_pre_pc got %h exp %h", pc_f, 32'h3010); end
    n_vec++; if (bd_f !== 1'b1) begin n_fail++; $display("FAIL stall_pre_bd got %b exp 1", bd_f); end
    stall = 1'b1;
    redir_valid = 1'b1;
    redir_target = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (pc_f !== 32'h3010) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp %h", i, pc_f, 32'h3010); end
      n_vec++; if (bd_f !== 1'b1) begin n_fail++; $display("FAIL stall_bd[%0d] got %b exp 1", i, bd_f); end
    end
    stall = 1'b0;
    redir_valid = 1'b0;
    tick();
    n_vec++; if (pc_f !== 32'h3014) begin n_fail++; $display("FAIL stall_rel_pc got %h exp %h", pc_f, 32'h3014); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL stall_rel_bd got %b exp 0", bd_f); end
  endtask

  task automatic test_exc_priority();
    goto_3010();
    exc_req = 1'b1;
    stall = 1'b1;
    redir_valid = 1'b1;
    redir_target = 32'h3100;
    tick();
    stall = 1'b0;
    redir_valid = 1'b0;
    n_vec++; if (pc_f !== 32'h4180) begin n_fail++; $display("FAIL exc_pc got %h exp %h", pc_f, 32'h4180); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL exc_bd got %b exp 0", bd_f); end
    n_vec++; if (adel_f !== 1'b0) begin n_fail++; $display("FAIL exc_adel got %b exp 0", adel_f); end
    eret_m = 1'b1;
    epc = 32'h3200;
    tick();
    exc_req = 1'b0;
    eret_m = 1'b0;
    n_vec++; if (pc_f !== 32'h4180) begin n_fail++; $display("FAIL exc_over_eret got %h exp %h", pc_f, 32'h4180); end
  endtask

  task automatic test_eret_misaligned();
    eret_m = 1'b1;
    epc = 32'h3022;
    stall = 1'b1;
    tick();
    eret_m = 1'b0;
    stall = 1'b0;
    n_vec++; if (pc_f !== 32'h3022) begin n_fail++; $display("FAIL eret_pc got %h exp %h", pc_f, 32'h3022); end
    n_vec++; if (pc8_f !== 32'h302A) begin n_fail++; $display("FAIL eret_pc8 got %h exp %h", pc8_f, 32'h302A); end
    n_vec++; if (adel_f !== 1'b1) begin n_fail++; $display("FAIL eret_adel got %b exp 1", adel_f); end
    n_vec++; if (instr_f !== 32'h0) begin n_fail++; $display("FAIL eret_instr got %h exp 0", instr_f); end
    tick();
    n_vec++; if (pc_f !== 32'h3026) begin n_fail++; $display("FAIL eret_next_pc got %h exp %h", pc_f, 32'h3026); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL eret_next_bd got %b exp 0", bd_f); end
  endtask

  task automatic test_range();
    redir_valid = 1'b1;
    redir_target = 32'h7000;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc_f !== 32'h7000) begin n_fail++; $display("FAIL hi_pc got %h exp %h", pc_f, 32'h7000); end
    n_vec++; if (adel_f !== 1'b1) begin n_fail++; $display("FAIL hi_adel got %b exp 1", adel_f); end
    n_vec++; if (instr_f !== 32'h0) begin n_fail++; $display("FAIL hi_instr got %h exp 0", instr_f); end
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    n_vec++; if (pc_f !== 32'h4180) begin n_fail++; $display("FAIL hi_exc_pc got %h exp %h", pc_f, 32'h4180); end
    n_vec++; if (adel_f !== 1'b0) begin n_fail++; $display("FAIL hi_exc_adel got %b exp 0", adel_f); end
    redir_valid = 1'b1;
    redir_target = 32'h6FFC;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (adel_f !== 1'b0) begin n_fail++; $display("FAIL edge_hi_adel got %b exp 0", adel_f); end
    redir_valid = 1'b1;
    redir_target = 32'h2FFC;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (adel_f !== 1'b1) begin n_fail++; $display("FAIL lo_adel got %b exp 1", adel_f); end
    tick();
    n_vec++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL lo_next_pc got %h exp %h", pc_f, 32'h3000); end
    n_vec++; if (adel_f !== 1'b0) begin n_fail++; $display("FAIL lo_next_adel got %b exp 0", adel_f); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL lo_next_bd got %b exp 0", bd_f); end
    redir_valid = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc8_f !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_pc8 got %h exp %h", pc8_f, 32'h4); end
    tick();
    n_vec++; if (pc_f !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", pc_f); end
    n_vec++; if (adel_f !== 1'b1) begin n_fail++; $display("FAIL wrap_adel got %b exp 1", adel_f); end
  endtask

  task automatic test_reset_mid();
    goto_3010();
    stall = 1'b1;
    redir_valid = 1'b1;
    redir_target = 32'h3100;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    redir_valid = 1'b0;
    n_vec++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL rst_mid_pc got %h exp %h", pc_f, 32'h3000); end
    n_vec++; if (bd_f !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bd got %b exp 0", bd_f); end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    exc_req = 1'b0;
    eret_m = 1'b0;
    epc = 32'h0;
    redir_valid = 1'b0;
    redir_target = 32'h0;
    test_reset();
    test_sequential();
    test_redirect_bd();
    test_stall();
    test_exc_priority();
    test_eret_misaligned();
    test_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
